// File: rtl/vram_fill_engine.sv
// vram_fill_engine: once per frame, fills VRAM column-major from three scrolled layer ROMs with colour-key compositing.
// Optional build macro VRAM_FILL_CONTINUOUS_EN: free-running back-to-back frames, start ignored.
module vram_fill_engine #(
  parameter int         VRAM_L       = 19200,
  parameter int         LAYER_WIDTH  = 296,
  parameter int         LAYER_HEIGHT = 120,
  parameter int         LAYER_L      = LAYER_WIDTH * LAYER_HEIGHT,
  parameter logic [7:0] KEY          = 8'hE3,
  parameter logic [7:0] BG_COLOR     = 8'hC9,
  localparam int        OFF_W        = $clog2(LAYER_WIDTH),
  localparam int        ROM_W        = $clog2(LAYER_L),
  localparam int        PIX_W        = $clog2(VRAM_L)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OFF_W-1:0] offset0,
  input  logic [OFF_W-1:0] offset1,
  input  logic [OFF_W-1:0] offset2,
  output logic [ROM_W-1:0] rom_addr0,
  output logic [ROM_W-1:0] rom_addr1,
  output logic [ROM_W-1:0] rom_addr2,
  input  logic [7:0]       rom_data0,
  input  logic [7:0]       rom_data1,
  input  logic [7:0]       rom_data2,
  output logic             vram_wr_ena,
  output logic [PIX_W-1:0] vram_wr_addr,
  output logic [7:0]       vram_wr_data,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t           state, next_state;
  logic [PIX_W-1:0] pix_cnt;
  logic             last_pix;
  logic             drain_cnt;
  logic             launch;
  logic [OFF_W-1:0] offs [3];
  logic [ROM_W-1:0] ptr  [3];
  logic             s1_vld;
  logic [PIX_W-1:0] s1_addr;
  logic [7:0]       pixel;

  // Out-of-range offsets scroll to column 0; the multiply runs once per frame at launch.
  function automatic logic [ROM_W-1:0] base_of(input logic [OFF_W-1:0] off);
    if ({1'b0, off} >= (OFF_W+1)'(LAYER_WIDTH)) return '0;
    return ROM_W'(off) * ROM_W'(LAYER_HEIGHT);
  endfunction

`ifdef VRAM_FILL_CONTINUOUS_EN
  logic start_unused;
  assign start_unused = start;
  assign launch       = (state == IDLE);
`else
  assign launch       = (state == IDLE) && start;
`endif

  assign offs[0]   = offset0;
  assign offs[1]   = offset1;
  assign offs[2]   = offset2;
  assign rom_addr0 = ptr[0];
  assign rom_addr1 = ptr[1];
  assign rom_addr2 = ptr[2];
  assign last_pix  = (pix_cnt == PIX_W'(VRAM_L - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: default assignment first so no path through the case leaves next_state unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (launch)    next_state = FILL;
      FILL:    if (last_pix)  next_state = DRAIN;
      DRAIN:   if (drain_cnt) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Address generation: pointers load the latched base at launch, then step with wrap (no divider).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt   <= '0;
      drain_cnt <= 1'b0;
      for (int i = 0; i < 3; i++) ptr[i] <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (launch) begin
        pix_cnt <= '0;
        for (int i = 0; i < 3; i++) ptr[i] <= base_of(offs[i]);
      end else if (state == FILL) begin
        pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
        for (int i = 0; i < 3; i++)
          ptr[i] <= (ptr[i] == ROM_W'(LAYER_L - 1)) ? '0 : ptr[i] + 1'b1;
      end
    end
  end

  always_comb begin
    pixel = (rom_data0 != KEY) ? rom_data0 :
            (rom_data1 != KEY) ? rom_data1 :
            (rom_data2 != KEY) ? rom_data2 : BG_COLOR;
  end

  // Stage 1 tracks the pixel whose ROM data arrives this cycle; stage 2 is the VRAM write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld       <= 1'b0;
      s1_addr      <= '0;
      vram_wr_ena  <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= '0;
      frame_done   <= 1'b0;
    end else begin
      s1_vld       <= (state == FILL);
      s1_addr      <= pix_cnt;
      vram_wr_ena  <= s1_vld;
      vram_wr_addr <= s1_addr;
      frame_done   <= s1_vld && (s1_addr == PIX_W'(VRAM_L - 1));
      if (s1_vld) vram_wr_data <= pixel;
    end
  end

endmodule

// File: tb/tb_vram_fill_engine.sv
// Self-checking bench for vram_fill_engine (default one-shot build) against a frame-level reference model.
module tb_vram_fill_engine;

  localparam int         N   = 19200;
  localparam int         W   = 296;
  localparam int         H   = 120;
  localparam int         L   = W * H;
  localparam logic [7:0] KEY = 8'hE3;
  localparam logic [7:0] BG  = 8'hC9;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  offset0, offset1, offset2;
  logic [15:0] rom_addr0, rom_addr1, rom_addr2;
  logic [7:0]  rom_data0, rom_data1, rom_data2;
  logic        vram_wr_ena;
  logic [14:0] vram_wr_addr;
  logic [7:0]  vram_wr_data;
  logic        busy;
  logic        frame_done;

  int          errors = 0;
  int          checks = 0;

  // ROM content model: address LSBs, seeded hash with frequent KEY pixels, or per-layer forced constants.
  int          rom_mode = 0;
  logic [31:0] seed = 32'h1234_5678;
  logic        force_en  [3];
  logic [7:0]  force_val [3];

  always #5 clk = ~clk;

  vram_fill_engine dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .offset0      (offset0),
    .offset1      (offset1),
    .offset2      (offset2),
    .rom_addr0    (rom_addr0),
    .rom_addr1    (rom_addr1),
    .rom_addr2    (rom_addr2),
    .rom_data0    (rom_data0),
    .rom_data1    (rom_data1),
    .rom_data2    (rom_data2),
    .vram_wr_ena  (vram_wr_ena),
    .vram_wr_addr (vram_wr_addr),
    .vram_wr_data (vram_wr_data),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  function automatic logic [7:0] rom_val(input int layer, input int a);
    logic [31:0] x;
    if (force_en[layer]) return force_val[layer];
    if (rom_mode == 0) return a[7:0];
    x = 32'(a) * 32'h9E37_79B1;
    x = x ^ seed ^ (32'(layer) << 24);
    x = x ^ (x >> 15);
    x = x * 32'h85EB_CA6B;
    x = x ^ (x >> 13);
    return (x[9:8] < 2'd2) ? KEY : x[7:0];
  endfunction

  // Synchronous ROMs: data valid one clock after the address.
  always @(posedge clk) begin
    rom_data0 <= rom_val(0, int'(rom_addr0));
    rom_data1 <= rom_val(1, int'(rom_addr1));
    rom_data2 <= rom_val(2, int'(rom_addr2));
  end

  function automatic int eff_base(input int o);
    return (o >= W) ? 0 : o * H;
  endfunction

  // Pixel k is the top-most non-transparent layer at its scrolled address, else background.
  function automatic logic [7:0] expect_pixel(input int base[3], input int k);
    logic [7:0] v;
    for (int i = 0; i < 3; i++) begin
      v = rom_val(i, (base[i] + k) % L);
      if (v != KEY) return v;
    end
    return BG;
  endfunction

  // Caller drives start=1 (and offsets) at a negedge; the next posedge is E0. Cycle c counts from the
  // cycle after E0. Returns at the IDLE negedge after the frame, or after a reset abort at cycle reset_at.
  task automatic run_frame(input int repulse_at, input int offchg_at, input int reset_at,
                           output int a0_first, output int a0_119, output int a0_120,
                           output int a1_first, output logic [7:0] first_data);
    int          base [3];
    logic [15:0] ra   [3];
    int          addr_bad, wr_bad, busy_bad, done_bad, quiet_bad, nwr, ndone;
    string       addr_msg, wr_msg, busy_msg, done_msg;
    logic        exp_wr, exp_busy, exp_done;
    logic [7:0]  exp_data;
    addr_bad = 0; wr_bad = 0; busy_bad = 0; done_bad = 0; quiet_bad = 0; nwr = 0; ndone = 0;
    addr_msg = ""; wr_msg = ""; busy_msg = ""; done_msg = "";
    a0_first = -1; a0_119 = -1; a0_120 = -1; a1_first = -1; first_data = 8'h00;
    base[0] = eff_base(int'(offset0));
    base[1] = eff_base(int'(offset1));
    base[2] = eff_base(int'(offset2));
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; ; c++) begin
      if (reset_at >= 0 && c == reset_at) break;
      ra[0] = rom_addr0; ra[1] = rom_addr1; ra[2] = rom_addr2;
      if (c == 0)   begin a0_first = int'(rom_addr0); a1_first = int'(rom_addr1); end
      if (c == 119) a0_119 = int'(rom_addr0);
      if (c == 120) a0_120 = int'(rom_addr0);
      if (c == 2)   first_data = vram_wr_data;
      exp_busy = (c <= N + 1);
      exp_wr   = (c >= 2) && (c <= N + 1);
      exp_done = (c == N + 1);
      if (busy !== exp_busy) begin
        if (busy_bad == 0) busy_msg = $sformatf("cycle %0d busy=%b want %b", c, busy, exp_busy);
        busy_bad++;
      end
      if (c < N) begin
        for (int i = 0; i < 3; i++) begin
          if (ra[i] !== 16'((base[i] + c) % L)) begin
            if (addr_bad == 0)
              addr_msg = $sformatf("cycle %0d rom_addr%0d=%0d want %0d", c, i, ra[i], (base[i] + c) % L);
            addr_bad++;
          end
        end
      end
      if (vram_wr_ena === 1'b1) nwr++;
      if (frame_done === 1'b1) ndone++;
      if (vram_wr_ena !== exp_wr) begin
        if (wr_bad == 0) wr_msg = $sformatf("cycle %0d wr_ena=%b want %b", c, vram_wr_ena, exp_wr);
        wr_bad++;
      end else if (exp_wr) begin
        exp_data = expect_pixel(base, c - 2);
        if (vram_wr_addr !== 15'(c - 2) || vram_wr_data !== exp_data) begin
          if (wr_bad == 0)
            wr_msg = $sformatf("cycle %0d addr=%0d data=%h want addr=%0d data=%h",
                               c, vram_wr_addr, vram_wr_data, c - 2, exp_data);
          wr_bad++;
        end
      end
      if (frame_done !== exp_done) begin
        if (done_bad == 0) done_msg = $sformatf("cycle %0d frame_done=%b want %b", c, frame_done, exp_done);
        done_bad++;
      end
      if (c == N + 2) break;
      start = (c == repulse_at);
      if (c == offchg_at) offset0 = 9'd10;
      @(negedge clk);
    end
    checks++;
    if (addr_bad !== 0) begin errors++; $display("FAIL rom_addr: %0d bad, first %s", addr_bad, addr_msg); end
    checks++;
    if (wr_bad !== 0) begin errors++; $display("FAIL vram_write: %0d bad, first %s", wr_bad, wr_msg); end
    checks++;
    if (busy_bad !== 0) begin errors++; $display("FAIL busy: %0d bad, first %s", busy_bad, busy_msg); end
    checks++;
    if (done_bad !== 0) begin errors++; $display("FAIL frame_done: %0d bad, first %s", done_bad, done_msg); end
    if (reset_at < 0) begin
      checks++;
      if (nwr !== N) begin errors++; $display("FAIL write_count: got %0d want %0d", nwr, N); end
      checks++;
      if (ndone !== 1) begin errors++; $display("FAIL done_count: got %0d want 1", ndone); end
    end else begin
      rst = 1'b1;
      start = 1'b0;
      #1;
      checks++;
      if ({rom_addr0, rom_addr1, rom_addr2, vram_wr_ena, vram_wr_addr, vram_wr_data, busy, frame_done} !== '0) begin
        errors++;
        $display("FAIL async_reset: addr=%0d/%0d/%0d ena=%b waddr=%0d wdata=%h busy=%b done=%b want all 0",
                 rom_addr0, rom_addr1, rom_addr2, vram_wr_ena, vram_wr_addr, vram_wr_data, busy, frame_done);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (vram_wr_ena !== 1'b0 || busy !== 1'b0) quiet_bad++;
      end
      checks++;
      if (quiet_bad !== 0) begin errors++; $display("FAIL post_reset_quiet: %0d active cycles want 0", quiet_bad); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    offset0 = '0; offset1 = '0; offset2 = '0;
    for (int i = 0; i < 3; i++) begin force_en[i] = 1'b0; force_val[i] = 8'h00; end
    repeat (3) @(negedge clk);
    checks++;
    if ({rom_addr0, rom_addr1, rom_addr2} !== '0) begin
      errors++; $display("FAIL reset_rom_addr: got %0d/%0d/%0d want 0/0/0", rom_addr0, rom_addr1, rom_addr2);
    end
    checks++;
    if ({vram_wr_ena, vram_wr_addr, vram_wr_data} !== '0) begin
      errors++; $display("FAIL reset_vram: ena=%b addr=%0d data=%h want 0", vram_wr_ena, vram_wr_addr, vram_wr_data);
    end
    checks++;
    if ({busy, frame_done} !== 2'b00) begin
      errors++; $display("FAIL reset_status: busy=%b done=%b want 0/0", busy, frame_done);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, vram_wr_ena} !== 2'b00) begin
      errors++; $display("FAIL idle_no_start: busy=%b ena=%b want 0/0", busy, vram_wr_ena);
    end
  endtask

  task automatic test_frame_content();
    int a0f, a0a, a0b, a1f;
    logic [7:0] fd;
    rom_mode = 0;
    offset0 = '0; offset1 = '0; offset2 = '0;
    start = 1'b1;
    run_frame(-1, -1, -1, a0f, a0a, a0b, a1f, fd);
    checks++;
    if (a0f !== 0) begin errors++; $display("FAIL content_first_addr: got %0d want 0", a0f); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap_and_repulse();
    int a0f, a0a, a0b, a1f;
    logic [7:0] fd;
    rom_mode = 1;
    seed = $urandom;
    offset0 = 9'd295;
    offset1 = 9'd300;
    offset2 = 9'($urandom_range(0, W - 1));
    start = 1'b1;
    run_frame(3000, -1, -1, a0f, a0a, a0b, a1f, fd);
    checks++;
    if (a0f !== 35400) begin errors++; $display("FAIL wrap_first: got %0d want 35400", a0f); end
    checks++;
    if (a0a !== 35519) begin errors++; $display("FAIL wrap_pixel119: got %0d want 35519", a0a); end
    checks++;
    if (a0b !== 0) begin errors++; $display("FAIL wrap_pixel120: got %0d want 0", a0b); end
    checks++;
    if (a1f !== 0) begin errors++; $display("FAIL offset_out_of_range: got %0d want 0", a1f); end
  endtask

  // Starts in the first IDLE cycle after the previous frame and changes offset0 mid-frame.
  task automatic test_back_to_back();
    int a0f, a0a, a0b, a1f;
    logic [7:0] fd;
    seed = $urandom;
    offset0 = 9'd0;
    offset1 = 9'($urandom_range(0, 511));
    offset2 = 9'($urandom_range(0, W - 1));
    start = 1'b1;
    run_frame(-1, 5000, -1, a0f, a0a, a0b, a1f, fd);
    checks++;
    if (a0f !== 0) begin errors++; $display("FAIL b2b_first_addr: got %0d want 0", a0f); end
  endtask

  task automatic test_reset_mid_frame();
    int a0f, a0a, a0b, a1f;
    logic [7:0] fd;
    start = 1'b1;
    run_frame(-1, -1, 8000, a0f, a0a, a0b, a1f, fd);
    checks++;
    if (a0f !== 1200) begin errors++; $display("FAIL new_offset_first_addr: got %0d want 1200", a0f); end
  endtask

  task automatic test_composite();
    logic [7:0] fv  [3][3];
    logic [7:0] exp [3];
    int a0f, a0a, a0b, a1f;
    logic [7:0] fd;
    fv[0][0] = KEY;   fv[0][1] = 8'h1C; fv[0][2] = 8'($urandom); exp[0] = 8'h1C;
    fv[1][0] = KEY;   fv[1][1] = KEY;   fv[1][2] = KEY;          exp[1] = BG;
    fv[2][0] = 8'h03; fv[2][1] = 8'($urandom); fv[2][2] = KEY;   exp[2] = 8'h03;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 3; i++) begin force_en[i] = 1'b1; force_val[i] = fv[t][i]; end
      offset0 = '0; offset1 = '0; offset2 = '0;
      start = 1'b1;
      run_frame(-1, -1, 40, a0f, a0a, a0b, a1f, fd);
      checks++;
      if (fd !== exp[t]) begin errors++; $display("FAIL composite_%0d: got %h want %h", t, fd, exp[t]); end
      checks++;
      if (a0f !== 0) begin errors++; $display("FAIL restart_addr_%0d: got %0d want 0", t, a0f); end
    end
    for (int i = 0; i < 3; i++) force_en[i] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_content();
    test_wrap_and_repulse();
    test_back_to_back();
    test_reset_mid_frame();
    test_composite();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
